// File: rtl/fp_cvt_to_int.sv
// Multi-cycle SP/DP floating point to 32-bit signed/unsigned integer converter
// with RISC-V rounding modes and IEEE invalid/inexact flags; one operation in flight.
module fp_cvt_to_int #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sp_dp,
  input  logic                  in_unsigned,
  input  logic [2:0]            in_rm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_flag_nv,
  output logic                  out_flag_nx
);

  localparam int unsigned SIG_W = 53;
  localparam int unsigned EXP_W = 13;
  localparam int unsigned MAG_W = 33;
  localparam int unsigned RES_W = 32;
  localparam int unsigned SHF_W = 87;
  localparam int unsigned AMT_W = 6;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic signed [EXP_W-1:0] E_OVF      = EXP_W'(32);
  localparam logic signed [EXP_W-1:0] E_MIN_INT  = EXP_W'(-1);
  localparam logic signed [EXP_W-1:0] E_SHF_BASE = EXP_W'(31);

  localparam logic [RES_W-1:0] S_MAX = 32'h7FFF_FFFF;
  localparam logic [RES_W-1:0] S_MIN = 32'h8000_0000;
  localparam logic [RES_W-1:0] U_MAX = 32'hFFFF_FFFF;
  localparam logic [RES_W-1:0] U_MIN = 32'h0000_0000;
  localparam logic [MAG_W-1:0] S_POS_LIM = 33'h0_7FFF_FFFF;
  localparam logic [MAG_W-1:0] S_NEG_LIM = 33'h0_8000_0000;

  typedef struct packed {
    logic             sign;
    logic             nan;
    logic             inf;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             uns;
    logic [2:0]       rm;
  } op_t;

  logic [1:0] state_q, state_d;
  logic       load_op, load_shf, load_res, out_valid_d;

  op_t              op_in, op_q;
  logic [7:0]       sp_exp;
  logic [22:0]      sp_frac;
  logic [10:0]      dp_exp;
  logic [51:0]      dp_frac;

  logic signed [EXP_W-1:0] e_s;
  logic                    ovf_c, tiny_c;
  logic [AMT_W-1:0]        amt_c;
  logic [SHF_W-1:0]        shf_c;
  logic [MAG_W-1:0]        mag_c, mag_q;
  logic                    guard_c, sticky_c, guard_q, sticky_q, ovf_q;

  logic             inc_c;
  logic [MAG_W-1:0] mag_r_c;
  logic [RES_W-1:0] neg_r_c, res_c;
  logic             nv_c, nx_c;

  assign sp_exp  = in_data[30:23];
  assign sp_frac = in_data[22:0];
  assign dp_exp  = in_data[62:52];
  assign dp_frac = in_data[51:0];

  // Unpack the operand into sign, unbiased exponent and left-aligned significand
  always_comb begin
    op_in      = '0;
    op_in.uns  = in_unsigned;
    op_in.rm   = in_rm;
    if (in_sp_dp) begin
      op_in.sign = in_data[63];
      op_in.nan  = (&dp_exp) & (|dp_frac);
      op_in.inf  = (&dp_exp) & ~(|dp_frac);
      op_in.sig  = {|dp_exp, dp_frac};
      op_in.exp  = (dp_exp == '0) ? EXP_W'(-1022) : EXP_W'(dp_exp) - EXP_W'(1023);
    end else begin
      op_in.sign = in_data[31];
      op_in.nan  = (&sp_exp) & (|sp_frac);
      op_in.inf  = (&sp_exp) & ~(|sp_frac);
      op_in.sig  = {|sp_exp, sp_frac, 29'b0};
      op_in.exp  = (sp_exp == '0) ? EXP_W'(-126) : EXP_W'(sp_exp) - EXP_W'(127);
    end
  end

  // Alignment: base holds sig pre-shifted by 21, so the remaining shift is 31 - e
  assign e_s    = $signed(op_q.exp);
  assign ovf_c  = op_q.nan | op_q.inf | (e_s >= E_OVF);
  assign tiny_c = (e_s < E_MIN_INT);
  assign amt_c  = AMT_W'(E_SHF_BASE - e_s);
  assign shf_c  = {1'b0, op_q.sig, 33'b0} >> amt_c;

  always_comb begin
    mag_c    = shf_c[SHF_W-1:54];
    guard_c  = shf_c[53];
    sticky_c = |shf_c[52:0];
    if (ovf_c) begin
      mag_c    = '0;
      guard_c  = 1'b0;
      sticky_c = 1'b0;
    end else if (tiny_c) begin
      mag_c    = '0;
      guard_c  = 1'b0;
      sticky_c = |op_q.sig;
    end
  end

  always_comb begin
    inc_c = 1'b0;
    case (op_q.rm)
      RM_RNE:  inc_c = guard_q & (mag_q[0] | sticky_q);
      RM_RTZ:  inc_c = 1'b0;
      RM_RDN:  inc_c = op_q.sign & (guard_q | sticky_q);
      RM_RUP:  inc_c = ~op_q.sign & (guard_q | sticky_q);
      RM_RMM:  inc_c = guard_q;
      default: inc_c = 1'b0;
    endcase
  end

  assign mag_r_c = mag_q + MAG_W'(inc_c);
  assign neg_r_c = RES_W'(0) - mag_r_c[RES_W-1:0];

  // Range check; an invalid result never reports inexact
  always_comb begin
    res_c = op_q.sign ? neg_r_c : mag_r_c[RES_W-1:0];
    nv_c  = 1'b0;
    nx_c  = guard_q | sticky_q;
    if (ovf_q) begin
      nv_c = 1'b1;
      if (op_q.nan | ~op_q.sign) begin
        res_c = op_q.uns ? U_MAX : S_MAX;
      end else begin
        res_c = op_q.uns ? U_MIN : S_MIN;
      end
    end else if (op_q.uns) begin
      if (~op_q.sign & mag_r_c[RES_W]) begin
        nv_c  = 1'b1;
        res_c = U_MAX;
      end else if (op_q.sign & (mag_r_c != '0)) begin
        nv_c  = 1'b1;
        res_c = U_MIN;
      end
    end else begin
      if (~op_q.sign & (mag_r_c > S_POS_LIM)) begin
        nv_c  = 1'b1;
        res_c = S_MAX;
      end else if (op_q.sign & (mag_r_c > S_NEG_LIM)) begin
        nv_c  = 1'b1;
        res_c = S_MIN;
      end
    end
    if (nv_c) nx_c = 1'b0;
  end

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    load_op     = 1'b0;
    load_shf    = 1'b0;
    load_res    = 1'b0;
    out_valid_d = out_valid;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_op = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        load_shf = 1'b1;
        state_d  = ROUND;
      end
      ROUND: begin
        load_res    = 1'b1;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= out_valid_d;
    end
  end

  // Operand, alignment and result registers
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      op_q        <= '0;
      mag_q       <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      ovf_q       <= 1'b0;
      out_data    <= '0;
      out_flag_nv <= 1'b0;
      out_flag_nx <= 1'b0;
    end else begin
      if (load_op) op_q <= op_in;
      if (load_shf) begin
        mag_q    <= mag_c;
        guard_q  <= guard_c;
        sticky_q <= sticky_c;
        ovf_q    <= ovf_c;
      end
      if (load_res) begin
        out_data    <= {{(DATA_WIDTH-RES_W){res_c[RES_W-1]}}, res_c};
        out_flag_nv <= nv_c;
        out_flag_nx <= nx_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_cvt_to_int.sv
// Scoreboard bench for fp_cvt_to_int: directed vectors, handshake stall, mid-op reset.
module tb_fp_cvt_to_int;

  localparam int unsigned DW = 64;

  logic          in_clk, in_rst, in_valid, in_ready, in_sp_dp, in_unsigned;
  logic [2:0]    in_rm;
  logic [DW-1:0] in_data, out_data;
  logic          out_valid, out_ready, out_flag_nv, out_flag_nx;

  typedef struct {
    logic [63:0] data;
    logic        nv;
    logic        nx;
    bit          lat;
    int          t_in;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  fp_cvt_to_int #(.DATA_WIDTH(DW)) dut (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sp_dp    (in_sp_dp),
    .in_unsigned (in_unsigned),
    .in_rm       (in_rm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_flag_nv (out_flag_nv),
    .out_flag_nx (out_flag_nx)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;
  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, got, want);
  endtask

  // Drive one operation, wait for acceptance, and queue its expected response
  task automatic issue(input string nm, input logic [63:0] d, input logic dp, input logic uns,
                       input logic [2:0] rm, input logic [63:0] ed, input logic env,
                       input logic enx, input bit lat, input bit push);
    int   n;
    bit   ok;
    exp_t e;
    n = 0;
    ok = 1'b0;
    in_data = d;
    in_sp_dp = dp;
    in_unsigned = uns;
    in_rm = rm;
    in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge in_clk);
      if (in_ready) ok = 1'b1;
      else begin
        @(posedge in_clk);
        #1;
        n++;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL %s_accept: in_ready stayed %b, required 1 within 100 cycles", nm, in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge in_clk);
      #1;
      in_valid = 1'b0;
      if (push) begin
        e.data = ed;
        e.nv = env;
        e.nx = enx;
        e.lat = lat;
        e.t_in = cyc;
        e.name = nm;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge in_clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compare every presented result against the head of the scoreboard
  always @(negedge in_clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got data %h, required no output", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_data"}, out_data, e.data);
        chk({e.name, "_nv"}, 64'(out_flag_nv), 64'(e.nv));
        chk({e.name, "_nx"}, 64'(out_flag_nx), 64'(e.nx));
        if (e.lat) chk({e.name, "_cycles"}, 64'(cyc + 1 - e.t_in), 64'd3);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_sp_dp = 1'b0;
    in_unsigned = 1'b0;
    in_rm = 3'd0;
    out_ready = 1'b1;
    #1 in_rst = 1'b1;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_nv", 64'(out_flag_nv), 64'd0);
    chk("rst_nx", 64'(out_flag_nx), 64'd0);
    repeat (2) @(posedge in_clk);
    #1 in_rst = 1'b0;

    // Back-to-back directed vectors with out_ready held high
    issue("rne_2p5",       64'h0000_0000_4020_0000, 0, 0, 3'd0, 64'd2, 0, 1, 1, 1);
    issue("rtz_2p5",       64'h0000_0000_4020_0000, 0, 0, 3'd1, 64'd2, 0, 1, 1, 1);
    issue("rup_2p5",       64'h0000_0000_4020_0000, 0, 0, 3'd3, 64'd3, 0, 1, 1, 1);
    issue("rmm_2p5",       64'h0000_0000_4020_0000, 0, 0, 3'd4, 64'd3, 0, 1, 1, 1);
    issue("rdn_2p5",       64'h0000_0000_4020_0000, 0, 0, 3'd2, 64'd2, 0, 1, 1, 1);
    issue("rne_3p5",       64'h0000_0000_4060_0000, 0, 0, 3'd0, 64'd4, 0, 1, 1, 1);
    issue("rm6_3p5",       64'h0000_0000_4060_0000, 0, 0, 3'd6, 64'd3, 0, 1, 1, 1);
    issue("sp_hi_ignored", 64'hDEAD_BEEF_4020_0000, 0, 0, 3'd1, 64'd2, 0, 1, 1, 1);
    issue("rdn_m2p5",      64'h0000_0000_C020_0000, 0, 0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1, 1, 1);
    issue("rup_m2p5",      64'h0000_0000_C020_0000, 0, 0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1, 1);
    issue("dp_m1p5_rne",   64'hBFF8_0000_0000_0000, 1, 0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1, 1);
    issue("dp_m0p5_u",     64'hBFE0_0000_0000_0000, 1, 1, 3'd1, 64'd0, 0, 1, 1, 1);
    issue("dp_m1p5_u",     64'hBFF8_0000_0000_0000, 1, 1, 3'd1, 64'd0, 1, 0, 1, 1);
    issue("sp_2p31_s",     64'h0000_0000_4F00_0000, 0, 0, 3'd0, 64'h0000_0000_7FFF_FFFF, 1, 0, 1, 1);
    issue("sp_2p31_u",     64'h0000_0000_4F00_0000, 0, 1, 3'd0, 64'hFFFF_FFFF_8000_0000, 0, 0, 1, 1);
    issue("dp_m2p31_s",    64'hC1E0_0000_0000_0000, 1, 0, 3'd0, 64'hFFFF_FFFF_8000_0000, 0, 0, 1, 1);
    issue("dp_m2p31h_rtz", 64'hC1E0_0000_0010_0000, 1, 0, 3'd1, 64'hFFFF_FFFF_8000_0000, 0, 1, 1, 1);
    issue("dp_m2p31h_rdn", 64'hC1E0_0000_0010_0000, 1, 0, 3'd2, 64'hFFFF_FFFF_8000_0000, 1, 0, 1, 1);
    issue("dp_umax_rtz",   64'h41EF_FFFF_FFF0_0000, 1, 1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1, 1);
    issue("dp_umax_rne",   64'h41EF_FFFF_FFF0_0000, 1, 1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 1);
    issue("sp_2p32_u",     64'h0000_0000_4F80_0000, 0, 1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 1);
    issue("sp_qnan_s",     64'h0000_0000_7FC0_0000, 0, 0, 3'd0, 64'h0000_0000_7FFF_FFFF, 1, 0, 1, 1);
    issue("sp_qnan_u",     64'h0000_0000_7FC0_0000, 0, 1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 1);
    issue("dp_minf_u",     64'hFFF0_0000_0000_0000, 1, 1, 3'd0, 64'd0, 1, 0, 1, 1);
    issue("dp_minf_s",     64'hFFF0_0000_0000_0000, 1, 0, 3'd0, 64'hFFFF_FFFF_8000_0000, 1, 0, 1, 1);
    issue("sp_pzero",      64'h0000_0000_0000_0000, 0, 0, 3'd0, 64'd0, 0, 0, 1, 1);
    issue("sp_mzero_u",    64'h0000_0000_8000_0000, 0, 1, 3'd0, 64'd0, 0, 0, 1, 1);
    issue("sp_sub_rup",    64'h0000_0000_0000_0001, 0, 0, 3'd3, 64'd1, 0, 1, 1, 1);
    issue("dp_one_u",      64'h3FF0_0000_0000_0000, 1, 1, 3'd0, 64'd1, 0, 0, 1, 1);
    wait_drain();

    // Latency and stall with out_ready low; a pulsed in_valid must be ignored
    out_ready = 1'b0;
    issue("stall_rup_2p5", 64'h0000_0000_4020_0000, 0, 0, 3'd3, 64'd3, 0, 1, 0, 1);
    @(negedge in_clk);
    chk("lat_shift_valid", 64'(out_valid), 64'd0);
    @(negedge in_clk);
    chk("lat_round_valid", 64'(out_valid), 64'd0);
    @(negedge in_clk);
    chk("lat_done_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", out_data, 64'd3);
      chk("hold_nv", 64'(out_flag_nv), 64'd0);
      chk("hold_nx", 64'(out_flag_nx), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge in_clk);
      #1;
      in_valid = (i == 1);
      if (i == 1) in_data = 64'h3FF0_0000_0000_0000;
      @(negedge in_clk);
    end
    @(posedge in_clk);
    #1 out_ready = 1'b1;
    @(posedge in_clk);
    #1;
    chk("ready_after_out", 64'(in_ready), 64'd1);
    chk("valid_after_out", 64'(out_valid), 64'd0);

    // Reset while in SHIFT aborts the operation asynchronously
    issue("aborted", 64'h0000_0000_4020_0000, 0, 0, 3'd3, 64'd0, 0, 0, 0, 0);
    #2 in_rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_data", out_data, 64'd0);
    chk("abort_nx", 64'(out_flag_nx), 64'd0);
    @(posedge in_clk);
    #1 in_rst = 1'b0;
    issue("post_rst_m1p5", 64'hBFF8_0000_0000_0000, 1, 0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1, 1);
    wait_drain();
    repeat (3) @(posedge in_clk);
    #1;
    chk("final_in_ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
